// File: rtl/uart_pwm_pkg.sv
// Shared constants for the UART-to-PWM command controller: the frame sync
// byte, opcode bit positions inside the CMD byte and the parser state codes.
package uart_pwm_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    // CMD byte layout: bit 7 selects mask write, bits 3:0 select the channel
    localparam int         OP_MASK_BIT = 7;
    localparam int         CH_MSB      = 3;
    localparam int         CH_LSB      = 0;

    // Parser states, kept as plain constants for legacy tool compatibility
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CMD      = 3'd1;
    localparam logic [2:0] ST_DHI      = 3'd2;
    localparam logic [2:0] ST_DLO      = 3'd3;
    localparam logic [2:0] ST_CHK      = 3'd4;

endpackage

// File: rtl/uart_pwm_cmd_timeout.sv
// Inter-byte timeout counter for the command parser. Counts while enabled,
// is forced to zero by clear, and saturates at TIMEOUT_CYCLES-1 where it
// flags expiry instead of wrapping.
module uart_pwm_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 27_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign o_expire = (count_q == CNT_LAST);

    // Next count: clear wins, otherwise step while enabled and not yet at the limit
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && !o_expire) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_pwm_cmd_ctrl.sv
// Command controller between the UART receiver and the PWM channel bank.
// Parses SYNC/CMD/DHI/DLO frames into duty registers and an enable mask.
// Define UART_PWM_CMD_CHECKSUM_EN to add a trailing CHK byte that must equal
// CMD ^ DHI ^ DLO; without it a frame executes on its DLO byte.
module uart_pwm_cmd_ctrl
    import uart_pwm_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DUTY_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 27_000
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_rx_valid,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_break,
    output logic [NUM_CH*DUTY_BITS-1:0]   o_duty,
    output logic [NUM_CH-1:0]             o_pwm_en,
    output logic                          o_cfg_we,
    output logic                          o_frame_err,
    output logic                          o_busy
);

    logic [2:0]                  state_q, state_d;
    logic                        cmd_mask_q, cmd_mask_d;
    logic [3:0]                  cmd_ch_q, cmd_ch_d;
    logic [7:0]                  dhi_q, dhi_d;
`ifdef UART_PWM_CMD_CHECKSUM_EN
    logic [7:0]                  dlo_q, dlo_d;
    logic [7:0]                  chk_q, chk_d;
`endif
    logic [NUM_CH*DUTY_BITS-1:0] duty_q, duty_d;
    logic [NUM_CH-1:0]           pwm_en_q, pwm_en_d;
    logic                        cfg_we_q, cfg_we_d;
    logic                        frame_err_q, frame_err_d;

    logic                        byte_ok;
    logic                        brk;
    logic                        timeout_expire;
    logic                        exec;
    logic [7:0]                  exec_dlo;
    logic                        ch_valid;
    logic [15:0]                 raw_duty;
    logic [DUTY_BITS-1:0]        new_duty;
    logic [15:0]                 mask_wide;

    // A break qualified by valid overrides the byte, which is then not parsed
    assign byte_ok  = i_rx_valid && !i_rx_break;
    assign brk      = i_rx_valid && i_rx_break;

    assign ch_valid  = ({1'b0, cmd_ch_q} < 5'(NUM_CH));
    assign raw_duty  = {dhi_q, exec_dlo};
    assign new_duty  = raw_duty[DUTY_BITS-1:0];
    assign mask_wide = {8'h00, exec_dlo};

    uart_pwm_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  ((state_q == ST_IDLE) || byte_ok),
        .i_enable (state_q != ST_IDLE),
        .o_expire (timeout_expire)
    );

    // Frame parser and register-file update; break and timeout abort a frame first
    always_comb begin
        state_d     = state_q;
        cmd_mask_d  = cmd_mask_q;
        cmd_ch_d    = cmd_ch_q;
        dhi_d       = dhi_q;
`ifdef UART_PWM_CMD_CHECKSUM_EN
        dlo_d       = dlo_q;
        chk_d       = chk_q;
`endif
        duty_d      = duty_q;
        pwm_en_d    = pwm_en_q;
        cfg_we_d    = 1'b0;
        frame_err_d = 1'b0;
        exec        = 1'b0;
        exec_dlo    = 8'h00;

        if (brk) begin
            if (state_q != ST_IDLE) begin
                frame_err_d = 1'b1;
                state_d     = ST_IDLE;
            end
        end else if ((state_q != ST_IDLE) && timeout_expire) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
        end else if (byte_ok) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_data == SYNC_BYTE) begin
                        state_d = ST_CMD;
`ifdef UART_PWM_CMD_CHECKSUM_EN
                        chk_d   = 8'h00;
`endif
                    end
                end
                ST_CMD: begin
                    cmd_mask_d = i_rx_data[OP_MASK_BIT];
                    cmd_ch_d   = i_rx_data[CH_MSB:CH_LSB];
`ifdef UART_PWM_CMD_CHECKSUM_EN
                    chk_d      = chk_q ^ i_rx_data;
`endif
                    state_d    = ST_DHI;
                end
                ST_DHI: begin
                    dhi_d   = i_rx_data;
`ifdef UART_PWM_CMD_CHECKSUM_EN
                    chk_d   = chk_q ^ i_rx_data;
`endif
                    state_d = ST_DLO;
                end
`ifdef UART_PWM_CMD_CHECKSUM_EN
                ST_DLO: begin
                    dlo_d   = i_rx_data;
                    chk_d   = chk_q ^ i_rx_data;
                    state_d = ST_CHK;
                end
                ST_CHK: begin
                    if (i_rx_data == chk_q) begin
                        exec     = 1'b1;
                        exec_dlo = dlo_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
`else
                ST_DLO: begin
                    exec     = 1'b1;
                    exec_dlo = i_rx_data;
                    state_d  = ST_IDLE;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (exec) begin
            if (cmd_mask_q) begin
                pwm_en_d = mask_wide[NUM_CH-1:0];
                cfg_we_d = 1'b1;
            end else if (ch_valid) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (cmd_ch_q == 4'(k)) begin
                        duty_d[k*DUTY_BITS +: DUTY_BITS] = new_duty;
                    end
                end
                cfg_we_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    // State, frame capture and configuration registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cmd_mask_q  <= 1'b0;
            cmd_ch_q    <= 4'h0;
            dhi_q       <= 8'h00;
`ifdef UART_PWM_CMD_CHECKSUM_EN
            dlo_q       <= 8'h00;
            chk_q       <= 8'h00;
`endif
            duty_q      <= '0;
            pwm_en_q    <= '0;
            cfg_we_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_mask_q  <= cmd_mask_d;
            cmd_ch_q    <= cmd_ch_d;
            dhi_q       <= dhi_d;
`ifdef UART_PWM_CMD_CHECKSUM_EN
            dlo_q       <= dlo_d;
            chk_q       <= chk_d;
`endif
            duty_q      <= duty_d;
            pwm_en_q    <= pwm_en_d;
            cfg_we_q    <= cfg_we_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_duty      = duty_q;
    assign o_pwm_en    = pwm_en_q;
    assign o_cfg_we    = cfg_we_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_pwm_cmd_ctrl.sv
// Directed bench for uart_pwm_cmd_ctrl (default parameters). Follows the
// UART_PWM_CMD_CHECKSUM_EN build option to append the CHK byte to frames.
module tb_uart_pwm_cmd_ctrl;

    localparam int NUM_CH    = 4;
    localparam int DUTY_BITS = 16;
    localparam int TIMEOUT   = 27_000;

    logic                        clk;
    logic                        reset;
    logic                        rx_valid;
    logic [7:0]                  rx_data;
    logic                        rx_break;
    logic [NUM_CH*DUTY_BITS-1:0] duty;
    logic [NUM_CH-1:0]           pwm_en;
    logic                        cfg_we;
    logic                        frame_err;
    logic                        busy;

    int checks;
    int errors;

    uart_pwm_cmd_ctrl #(
        .NUM_CH         (NUM_CH),
        .DUTY_BITS      (DUTY_BITS),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .i_rx_break  (rx_break),
        .o_duty      (duty),
        .o_pwm_en    (pwm_en),
        .o_cfg_we    (cfg_we),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    // 100 MHz bench clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1 time unit after an edge; presents one byte for exactly one edge
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_break();
        rx_valid = 1'b1;
        rx_break = 1'b1;
        rx_data  = 8'hA5;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_break = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full frame, bytes back to back; returns in the cycle after the last byte
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] dhi, input logic [7:0] dlo);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(dhi);
        send_byte(dlo);
`ifdef UART_PWM_CMD_CHECKSUM_EN
        send_byte(cmd ^ dhi ^ dlo);
`endif
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_break = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycle();
        checks++; if (duty !== 64'h0) begin errors++; $display("[TB] FAIL reset_duty: got %h want 0", duty); end
        checks++; if (pwm_en !== 4'h0) begin errors++; $display("[TB] FAIL reset_en: got %b want 0000", pwm_en); end
        checks++; if (cfg_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_we: got %b want 0", cfg_we); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_duty();
        send_byte(8'hA5);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL duty_busy_mid: got %b want 1", busy); end
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
`ifdef UART_PWM_CMD_CHECKSUM_EN
        send_byte(8'h24);
`endif
        checks++; if (cfg_we !== 1'b1) begin errors++; $display("[TB] FAIL duty_cfg_we: got %b want 1", cfg_we); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL duty_err: got %b want 0", frame_err); end
        checks++; if (duty !== 64'h0000_1234_0000_0000) begin errors++; $display("[TB] FAIL duty_ch2: got %h want 0000123400000000", duty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL duty_busy_end: got %b want 0", busy); end
        idle_cycle();
        checks++; if (cfg_we !== 1'b0) begin errors++; $display("[TB] FAIL duty_cfg_we_pulse: got %b want 0", cfg_we); end
    endtask

    task automatic test_write_mask();
        send_frame(8'h80, 8'h00, 8'h0B);
        checks++; if (pwm_en !== 4'b1011) begin errors++; $display("[TB] FAIL mask_en: got %b want 1011", pwm_en); end
        checks++; if (cfg_we !== 1'b1) begin errors++; $display("[TB] FAIL mask_cfg_we: got %b want 1", cfg_we); end
        checks++; if (duty !== 64'h0000_1234_0000_0000) begin errors++; $display("[TB] FAIL mask_duty: got %h want 0000123400000000", duty); end
        idle_cycle();
    endtask

    task automatic test_bad_channel();
        send_frame(8'h07, 8'h00, 8'h10);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL badch_err: got %b want 1", frame_err); end
        checks++; if (cfg_we !== 1'b0) begin errors++; $display("[TB] FAIL badch_cfg_we: got %b want 0", cfg_we); end
        checks++; if (duty !== 64'h0000_1234_0000_0000) begin errors++; $display("[TB] FAIL badch_duty: got %h want 0000123400000000", duty); end
        idle_cycle();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL badch_err_pulse: got %b want 0", frame_err); end
    endtask

    task automatic test_bad_checksum();
`ifdef UART_PWM_CMD_CHECKSUM_EN
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'hFF);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL badchk_err: got %b want 1", frame_err); end
        checks++; if (cfg_we !== 1'b0) begin errors++; $display("[TB] FAIL badchk_cfg_we: got %b want 0", cfg_we); end
        checks++; if (duty !== 64'h0000_1234_0000_0000) begin errors++; $display("[TB] FAIL badchk_duty: got %h want 0000123400000000", duty); end
        idle_cycle();
`endif
    endtask

    task automatic test_noise_resync();
        logic [7:0] noise [3];
        noise[0] = 8'h00;
        noise[1] = 8'hFF;
        noise[2] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            send_byte(noise[i]);
            checks++; if (busy !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("[TB] FAIL noise_%0d: busy=%b err=%b want 0 0", i, busy, frame_err); end
        end
        send_frame(8'h01, 8'hAB, 8'hCD);
        checks++; if (duty !== 64'h0000_1234_ABCD_0000) begin errors++; $display("[TB] FAIL noise_duty: got %h want 00001234ABCD0000", duty); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL noise_err: got %b want 0", frame_err); end
        idle_cycle();
    endtask

    task automatic test_sync_as_data();
        send_frame(8'h03, 8'hA5, 8'hA5);
        checks++; if (duty !== 64'hA5A5_1234_ABCD_0000) begin errors++; $display("[TB] FAIL a5data_duty: got %h want A5A51234ABCD0000", duty); end
        checks++; if (cfg_we !== 1'b1) begin errors++; $display("[TB] FAIL a5data_cfg_we: got %b want 1", cfg_we); end
        idle_cycle();
    endtask

    task automatic test_timeout();
        int  n;
        bit  seen;
        send_byte(8'hA5);
        send_byte(8'h01);
        n    = 0;
        seen = 0;
        while (!seen && n < TIMEOUT + 20) begin
            idle_cycle();
            n++;
            if (frame_err === 1'b1) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL timeout_seen: no error within %0d cycles", n); end
        checks++; if (n != TIMEOUT) begin errors++; $display("[TB] FAIL timeout_latency: got %0d cycles want %0d", n, TIMEOUT); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy: got %b want 0", busy); end
        checks++; if (duty !== 64'hA5A5_1234_ABCD_0000) begin errors++; $display("[TB] FAIL timeout_duty: got %h want A5A51234ABCD0000", duty); end
        idle_cycle();
    endtask

    task automatic test_break();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_break();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL break_err: got %b want 1", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL break_busy: got %b want 0", busy); end
        idle_cycle();
        send_break();
        checks++; if (frame_err !== 1'b0 || cfg_we !== 1'b0) begin errors++; $display("[TB] FAIL break_idle: err=%b cfg_we=%b want 0 0", frame_err, cfg_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL break_idle_busy: got %b want 0 (A5 with break must not sync)", busy); end
        idle_cycle();
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h12);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (duty !== 64'h0 || pwm_en !== 4'h0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_outputs: duty=%h en=%b busy=%b want 0", duty, pwm_en, busy); end
        idle_cycle();
        reset = 1'b0;
        idle_cycle();
        send_frame(8'h00, 8'h55, 8'h55);
        checks++; if (duty !== 64'h0000_0000_0000_5555) begin errors++; $display("[TB] FAIL midreset_frame: got %h want 0000000000005555", duty); end
        checks++; if (cfg_we !== 1'b1) begin errors++; $display("[TB] FAIL midreset_cfg_we: got %b want 1", cfg_we); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        send_frame(8'h02, 8'h0B, 8'hAD);
        checks++; if (duty !== 64'h0000_0BAD_0000_5555) begin errors++; $display("[TB] FAIL b2b_first: got %h want 00000BAD00005555", duty); end
        send_byte(8'hA5);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_sync: busy got %b want 1", busy); end
        send_byte(8'h00);
        send_byte(8'h0F);
        send_byte(8'h0F);
`ifdef UART_PWM_CMD_CHECKSUM_EN
        send_byte(8'h00);
`endif
        checks++; if (duty !== 64'h0000_0BAD_0000_0F0F) begin errors++; $display("[TB] FAIL b2b_second: got %h want 00000BAD00000F0F", duty); end
        idle_cycle();
    endtask

    // Scenario sequence
    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_break = 1'b0;
        test_reset();
        test_write_duty();
        test_write_mask();
        test_bad_channel();
        test_bad_checksum();
        test_noise_resync();
        test_sync_as_data();
        test_timeout();
        test_break();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
